// File: rtl/accel_pkg.sv
// Shared types for the hash checker: FSM state encoding and hash width.
package accel_pkg;
  localparam int HASH_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/accel_hash_checker.sv
// Compares a 256-bit hash against a difficulty target one WORD_W slice per cycle,
// MSB slice first, and hands the found/nonce result off with a valid/ready handshake.
module accel_hash_checker
  import accel_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hash_valid,
  input  logic [HASH_W-1:0] hash,
  input  logic [31:0]       nonce,
  input  logic              target_load,
  input  logic [HASH_W-1:0] target_data,
  input  logic              clear_counts,
  input  logic              result_ready,
  output logic              result_valid,
  output logic              result_found,
  output logic [31:0]       result_nonce,
  output logic              busy,
  output logic              hash_drop,
  output logic [31:0]       attempt_count,
  output logic [31:0]       found_count
);
  localparam int NWORDS = HASH_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [HASH_W-1:0]   hash_q, snap_q, target_q;
  logic [31:0]         nonce_q;
  logic [WORD_W-1:0]   h_sl, t_sl;
  logic                accept, found_done;

  assign h_sl       = hash_q[idx*WORD_W +: WORD_W];
  assign t_sl       = snap_q[idx*WORD_W +: WORD_W];
  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) && hash_valid;
  assign found_done = (state == REPORT) && result_ready && result_found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      hash_q        <= '0;
      snap_q        <= '0;
      nonce_q       <= '0;
      target_q      <= '1;
      result_valid  <= 1'b0;
      result_found  <= 1'b0;
      result_nonce  <= '0;
      hash_drop     <= 1'b0;
      attempt_count <= '0;
      found_count   <= '0;
    end else begin
      hash_drop <= hash_valid && (state != IDLE);
      if (target_load) target_q <= target_data;

      // clear wins over a same-cycle increment; both counters stick at all-ones
      if (clear_counts)                     attempt_count <= '0;
      else if (accept && ~&attempt_count)   attempt_count <= attempt_count + 32'd1;
      if (clear_counts)                     found_count   <= '0;
      else if (found_done && ~&found_count) found_count   <= found_count + 32'd1;

      case (state)
        IDLE: if (hash_valid) begin
          hash_q  <= hash;
          nonce_q <= nonce;
          snap_q  <= target_load ? target_data : target_q;
          idx     <= IDX_W'(NWORDS - 1);
          state   <= CMP;
        end
        CMP: begin
          // first differing slice decides; all-equal means hash == target, i.e. found
          if (h_sl != t_sl || idx == '0) begin
            state        <= REPORT;
            result_valid <= 1'b1;
            result_found <= (h_sl <= t_sl);
            result_nonce <= nonce_q;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        REPORT: if (result_ready) begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
